// File: rtl/fifo_fwft_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_fwft_serializer
// Description : Read-side consumer of a first-word-fall-through FIFO. Pops
//               IN_WIDTH-bit words and emits each one as RATIO narrower beats
//               on a valid/ready stream, flagging the final beat with
//               out_last. Sustains one beat per cycle with no bubble between
//               consecutive words.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_fwft_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IN_WIDTH-1:0]         fifo_dout,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    output logic [IN_WIDTH/RATIO-1:0]   out_data,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int OUT_WIDTH = IN_WIDTH / RATIO;
    localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    // Slice table is padded to a power of two so the beat index always
    // addresses a defined entry, including the RATIO==1 case.
    localparam int SLOTS     = 1 << CNT_W;

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(RATIO - 1);

    // Reject configurations that cannot split a word into equal beats.
    if ((RATIO < 1) || ((IN_WIDTH % RATIO) != 0)) begin : g_bad_cfg
        $error("fifo_fwft_serializer: IN_WIDTH must be a multiple of RATIO (RATIO >= 1)");
    end

    logic [IN_WIDTH-1:0]  r_word;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_full;

    logic                 w_accept;
    logic                 w_word_done;
    logic [CNT_W-1:0]     w_slot_idx;
    logic [OUT_WIDTH-1:0] w_slices [SLOTS];

    // Cut the held word into its beats; unused padding slots read as zero.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slice
        if (gi < RATIO) begin : g_used
            assign w_slices[gi] = r_word[gi*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_pad
            assign w_slices[gi] = '0;
        end
    end

    // Handshake decode and the combinational pop request. A pop is allowed
    // when the holding register is free or is releasing its last beat now,
    // which is what gives back-to-back words without an idle cycle.
    always_comb begin
        w_accept    = r_full & out_ready;
        w_word_done = w_accept & (r_cnt == c_last_beat);
        fifo_rd_en  = rst_n & ~fifo_empty & (~r_full | w_word_done);
    end

    // Holding register and beat counter; a fresh pop takes priority over
    // retiring the current word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (fifo_rd_en) begin
            r_word <= fifo_dout;
            r_cnt  <= '0;
            r_full <= 1'b1;
        end else if (w_word_done) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Beat selection: counter order for LSB-first, mirrored for MSB-first.
    always_comb begin
        w_slot_idx = (LSB_FIRST != 0) ? r_cnt : (c_last_beat - r_cnt);
        out_valid  = r_full;
        busy       = r_full;
        out_last   = r_full & (r_cnt == c_last_beat);
        out_data   = r_full ? w_slices[w_slot_idx] : '0;
    end

endmodule
`default_nettype wire
